ps2_keycode_decoder: RTL and testbench

PS2_KEYCODE_DECODER -- requirements
Module: ps2_keycode_decoder

---
 rtl/ps2_keycode_decoder_if.sv | 25 ++
 rtl/ps2_keycode_decoder.sv | 197 +++++++++++++++++++
 tb/tb_ps2_keycode_decoder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keycode_decoder_if.sv
// Keyboard-side signals of the PS/2 keycode decoder.
// The master drives the PS/2 lines and the slave returns the decoded key state.
interface ps2_keycode_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_event;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keycode,
        input  key_event,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keycode,
        output key_event,
        output frame_err
    );
endinterface

// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 frame receiver with a watchdog, plus a scan-code to HID usage
// translator that tracks the most recently pressed mapped key.
module ps2_keycode_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    ps2_keycode_decoder_if.slave  bus
);

    localparam int unsigned WDOG_W = 16;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    // Scan code (with extended prefix) to HID usage; 8'h00 means unmapped.
    function automatic logic [7:0] translate(input logic ext, input logic [7:0] code);
        logic [7:0] usage;
        case ({ext, code})
            9'h01C:  usage = 8'h04;
            9'h023:  usage = 8'h07;
            9'h01D:  usage = 8'h1A;
            9'h01B:  usage = 8'h16;
            9'h029:  usage = 8'h2C;
            9'h05A:  usage = 8'h28;
            9'h076:  usage = 8'h29;
            9'h16B:  usage = 8'h50;
            9'h174:  usage = 8'h4F;
            9'h175:  usage = 8'h52;
            9'h172:  usage = 8'h51;
            default: usage = 8'h00;
        endcase
        return usage;
    endfunction

    logic [1:0]        clk_sync_q;
    logic [1:0]        dat_sync_q;
    logic              clk_prev_q;
    state_e            state_q,     state_d;
    logic [7:0]        shift_q,     shift_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic              parity_q,    parity_d;
    logic [WDOG_W-1:0] wdog_q,      wdog_d;
    logic [7:0]        byte_q,      byte_d;
    logic              byte_vld_q,  byte_vld_d;
    logic              ext_q,       ext_d;
    logic              brk_q,       brk_d;
    logic [7:0]        keycode_q,   keycode_d;
    logic              key_event_q, key_event_d;
    logic              frame_err_q, frame_err_d;

    logic              fall_c;
    logic              ps2_dat_c;
    logic [7:0]        usage_c;

    // Two-flop synchronizers; lines idle high so reset to 1 to avoid a false edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign fall_c    = clk_prev_q & ~clk_sync_q[1];
    assign ps2_dat_c = dat_sync_q[1];
    assign usage_c   = translate(ext_q, byte_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            parity_q    <= 1'b0;
            wdog_q      <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keycode_q   <= 8'h00;
            key_event_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            parity_q    <= parity_d;
            wdog_q      <= wdog_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keycode_q   <= keycode_d;
            key_event_q <= key_event_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        parity_d    = parity_q;
        wdog_d      = wdog_q;
        byte_d      = byte_q;
        byte_vld_d  = 1'b0;
        ext_d       = ext_q;
        brk_d       = brk_q;
        keycode_d   = keycode_q;
        key_event_d = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == S_IDLE || fall_c) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WDOG_W'(1);
        end

        // Frame reception: one transition per PS/2 falling edge.
        if (fall_c) begin
            case (state_q)
                S_IDLE: begin
                    if (!ps2_dat_c) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {ps2_dat_c, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = ps2_dat_c;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (ps2_dat_c && (^{shift_q, parity_q})) begin
                        byte_d     = shift_q;
                        byte_vld_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && wdog_q >= WDOG_W'(TIMEOUT_CYCLES)) begin
            state_d     = S_IDLE;
            shift_d     = '0;
            bit_cnt_d   = '0;
            parity_d    = 1'b0;
            frame_err_d = 1'b1;
        end

        // Byte decode runs the cycle after an accepted stop bit.
        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (usage_c != 8'h00) begin
                    key_event_d = 1'b1;
                    if (!brk_q) begin
                        keycode_d = usage_c;
                    end else if (keycode_q == usage_c) begin
                        keycode_d = 8'h00;
                    end
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

        if (frame_err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    assign bus.keycode   = keycode_q;
    assign bus.key_event = key_event_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Bench for ps2_keycode_decoder: directed scenarios plus random frame streams
// compared against a byte-level key-state model.
module tb_ps2_keycode_decoder;

    localparam int unsigned TO = 300;

    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    ps2_keycode_decoder_if bus ();

    ps2_keycode_decoder #(.TIMEOUT_CYCLES(TO)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #10 Clk = ~Clk;

    // Pulse monitor on the inactive edge.
    int   ev_cnt = 0, err_cnt = 0, overlap_cnt = 0, long_cnt = 0;
    logic ke_prev = 1'b0, fe_prev = 1'b0;
    always @(negedge Clk) begin
        if (bus.key_event === 1'b1) ev_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.key_event === 1'b1 && bus.frame_err === 1'b1) overlap_cnt++;
        if ((bus.key_event === 1'b1 && ke_prev) || (bus.frame_err === 1'b1 && fe_prev)) long_cnt++;
        ke_prev = (bus.key_event === 1'b1);
        fe_prev = (bus.frame_err === 1'b1);
    end

    // Reference model: key state from the byte stream.
    logic [7:0] usage_map [logic [8:0]];
    logic [7:0] m_kc  = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    int         exp_ev = 0, exp_err = 0;

    task automatic model_byte(input logic [7:0] b);
        logic [8:0] key;
        key = {m_ext, b};
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (usage_map.exists(key)) begin
                exp_ev++;
                if (!m_brk) m_kc = usage_map[key];
                else if (m_kc == usage_map[key]) m_kc = 8'h00;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            wait_clk(4);
            bus.ps2_clk = 1'b0;
            wait_clk(6);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
        logic       par;
        logic [10:0] bits;
        par  = (~^code) ^ bad_par;
        bits = {~bad_stop, par, code, 1'b0};
        send_bits(bits, 11);
        wait_clk(10);
        if (bad_par || bad_stop) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            model_byte(code);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_clk(5);
        checks++;
        if (bus.keycode !== 8'h00 || bus.key_event !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: kc=%h ev=%b err=%b want 00/0/0", bus.keycode, bus.key_event, bus.frame_err);
        end
        Reset = 1'b0;
        wait_clk(10);
        checks++;
        if (ev_cnt !== 0 || err_cnt !== 0 || bus.keycode !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: ev=%0d err=%0d kc=%h want 0/0/00", ev_cnt, err_cnt, bus.keycode);
        end
    endtask

    task automatic test_single_make;
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h04 || ev_cnt !== 1 || err_cnt !== 0) begin
            errors++;
            $display("FAIL make_1C: kc=%h ev=%0d err=%0d want 04/1/0", bus.keycode, ev_cnt, err_cnt);
        end
    endtask

    task automatic test_extended;
        int ev0;
        ev0 = ev_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h50) begin
            errors++;
            $display("FAIL ext_make: kc=%h want 50", bus.keycode);
        end
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h00 || ev_cnt - ev0 !== 2) begin
            errors++;
            $display("FAIL ext_break: kc=%h events=%0d want 00/2", bus.keycode, ev_cnt - ev0);
        end
    endtask

    task automatic test_overlap_keys;
        int ev0;
        ev0 = ev_cnt;
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h04) begin
            errors++;
            $display("FAIL seq_a: kc=%h want 04", bus.keycode);
        end
        send_frame(8'h23, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h07) begin
            errors++;
            $display("FAIL seq_d: kc=%h want 07", bus.keycode);
        end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h07 || ev_cnt - ev0 !== 3) begin
            errors++;
            $display("FAIL seq_brk_a: kc=%h events=%0d want 07/3", bus.keycode, ev_cnt - ev0);
        end
    endtask

    task automatic test_frame_errors;
        int ev0, er0;
        ev0 = ev_cnt;
        er0 = err_cnt;
        send_frame(8'h23, 1'b1, 1'b0);
        checks++;
        if (err_cnt - er0 !== 1 || ev_cnt !== ev0 || bus.keycode !== 8'h07) begin
            errors++;
            $display("FAIL parity_err: errs=%0d events=%0d kc=%h want 1/0/07", err_cnt - er0, ev_cnt - ev0, bus.keycode);
        end
        // A prefix lost to a bad stop bit must not turn the next code into a break.
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b0);
        checks++;
        if (err_cnt - er0 !== 2 || bus.keycode !== 8'h28) begin
            errors++;
            $display("FAIL stop_err: errs=%0d kc=%h want 2/28", err_cnt - er0, bus.keycode);
        end
    endtask

    task automatic test_idle_noise;
        int ev0, er0;
        ev0 = ev_cnt;
        er0 = err_cnt;
        send_bits(11'h7FF, 3);
        wait_clk(TO + 20);
        checks++;
        if (err_cnt !== er0 || ev_cnt !== ev0) begin
            errors++;
            $display("FAIL idle_noise: errs=%0d events=%0d want 0/0", err_cnt - er0, ev_cnt - ev0);
        end
    endtask

    task automatic test_timeout;
        int er0;
        er0 = err_cnt;
        send_bits({3'b111, 8'h15, 1'b0}, 4);
        wait_clk(TO - 20);
        checks++;
        if (err_cnt !== er0) begin
            errors++;
            $display("FAIL timeout_early: errs=%0d want 0", err_cnt - er0);
        end
        wait_clk(30);
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        checks++;
        if (err_cnt - er0 !== 1) begin
            errors++;
            $display("FAIL timeout_fire: errs=%0d want 1", err_cnt - er0);
        end
        send_frame(8'h29, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h2C || err_cnt - er0 !== 1) begin
            errors++;
            $display("FAIL timeout_recover: kc=%h errs=%0d want 2C/1", bus.keycode, err_cnt - er0);
        end
    endtask

    task automatic test_typematic;
        int ev0;
        ev0 = ev_cnt;
        for (int i = 0; i < 3; i++) send_frame(8'h76, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h29 || ev_cnt - ev0 !== 3) begin
            errors++;
            $display("FAIL typematic: kc=%h events=%0d want 29/3", bus.keycode, ev_cnt - ev0);
        end
    endtask

    task automatic test_reset_midframe;
        send_frame(8'h23, 1'b0, 1'b0);
        send_bits({3'b111, 8'h1D, 1'b0}, 5);
        bus.ps2_clk = 1'b0;
        wait_clk(2);
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.keycode !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: kc=%h want 00", bus.keycode);
        end
        m_kc  = 8'h00;
        m_ext = 1'b0;
        m_brk = 1'b0;
        bus.ps2_clk = 1'b1;
        wait_clk(3);
        Reset = 1'b0;
        wait_clk(5);
        send_frame(8'h1D, 1'b0, 1'b0);
        checks++;
        if (bus.keycode !== 8'h1A) begin
            errors++;
            $display("FAIL reset_recover: kc=%h want 1A", bus.keycode);
        end
    endtask

    task automatic test_random;
        logic [7:0] pool [13];
        logic [7:0] code;
        logic       bad;
        logic       which;
        pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h5A, 8'h76,
                 8'h6B, 8'h74, 8'h75, 8'h72, 8'hE0, 8'hF0};
        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(0, 5) == 0) code = 8'($urandom);
            else code = pool[$urandom_range(0, 12)];
            bad   = ($urandom_range(0, 9) == 0);
            which = 1'($urandom);
            send_frame(code, bad & which, bad & ~which);
            checks++;
            if (bus.keycode !== m_kc) begin
                errors++;
                $display("FAIL random_kc[%0d]: code=%h kc=%h want %h", n, code, bus.keycode, m_kc);
            end
        end
    endtask

    task automatic test_totals;
        checks++;
        if (ev_cnt !== exp_ev || err_cnt !== exp_err) begin
            errors++;
            $display("FAIL totals: events=%0d errs=%0d want %0d/%0d", ev_cnt, err_cnt, exp_ev, exp_err);
        end
        checks++;
        if (overlap_cnt !== 0 || long_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_shape: overlap=%0d long=%0d want 0/0", overlap_cnt, long_cnt);
        end
    endtask

    initial begin
        usage_map[9'h01C] = 8'h04; usage_map[9'h023] = 8'h07;
        usage_map[9'h01D] = 8'h1A; usage_map[9'h01B] = 8'h16;
        usage_map[9'h029] = 8'h2C; usage_map[9'h05A] = 8'h28;
        usage_map[9'h076] = 8'h29; usage_map[9'h16B] = 8'h50;
        usage_map[9'h174] = 8'h4F; usage_map[9'h175] = 8'h52;
        usage_map[9'h172] = 8'h51;

        test_reset();
        test_single_make();
        test_extended();
        test_overlap_keys();
        test_frame_errors();
        test_idle_noise();
        test_timeout();
        test_typematic();
        test_reset_midframe();
        test_random();
        test_totals();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
